// File: rtl/lock_pkg.sv
// Shared types and constants for the lock front-end sequencer.
package lock_pkg;

  // Outcome state of the lock as seen by the sequencer.
  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_LOCKOUT  = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_RELOCK   = 2'd3
  } lock_state_e;

  // LED patterns the lock core shows for each outcome.
  localparam logic [3:0] LED_LOCKOUT     = 4'hF;
  localparam logic [3:0] LED_UNLOCK      = 4'hC;
  // Consecutive matching cycles before an LED pattern is believed.
  localparam int         LED_QUAL_CYCLES = 2;

  // Button lanes.
  localparam int BTN_NEXT  = 0;
  localparam int BTN_ENTER = 1;
  localparam int NUM_BTNS  = 2;

  // Largest of three cycle counts; sizes the shared state timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Button, LED and control signals between the sequencer and its environment.
interface lock_sequencer_if;
  logic       next_btn;
  logic       enter_btn;
  logic [3:0] lock_led;
  logic       next_ed;
  logic       enter_ed;
  logic       lock_rst_n;
  logic       locked_out;
  logic       unlocked;
  logic       busy;

  // Environment side: drives buttons and the LED value, watches the outputs.
  modport master (
    output next_btn, enter_btn, lock_led,
    input  next_ed, enter_ed, lock_rst_n, locked_out, unlocked, busy
  );

  // Sequencer side.
  modport slave (
    input  next_btn, enter_btn, lock_led,
    output next_ed, enter_ed, lock_rst_n, locked_out, unlocked, busy
  );
endinterface

// File: rtl/lock_sequencer_btn_conditioner.sv
// One push-button: 2-flop synchroniser, debounce counter, rising-edge strobe.
// rise is combinational and high in the cycle the debounced level is about
// to go 0->1, so a consumer registering it sees the edge 2+DEBOUNCE_CYCLES
// clocks after the raw input settles high.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser; sync_q[1] is the metastability-safe copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], raw};
  end

  // Debounce: count disagreeing cycles, flip the level once the run is long enough.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    rise  = 1'b0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = ~db_q;
        rise = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced level and run counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// Front-end for the 4-LED combination lock: conditions the next/enter
// buttons, paces single-cycle pulses into the lock core, watches the LED
// pattern for lockout/unlock outcomes and re-arms the core afterwards.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 1000,
  parameter int GAP_CYCLES       = 2,
  parameter int LOCKOUT_CYCLES   = 100000,
  parameter int UNLOCK_CYCLES    = 50000,
  parameter int RST_PULSE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  lock_sequencer_if.slave  bus
);

  localparam int TMAX = max3(LOCKOUT_CYCLES, UNLOCK_CYCLES, RST_PULSE_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int QW   = $clog2(LED_QUAL_CYCLES + 1);

  logic [NUM_BTNS-1:0] raw_btn, rise;

  lock_state_e         state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [QW-1:0]       qf_q, qf_d, qc_q, qc_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [NUM_BTNS-1:0] pend_q, pend_d, iss;
  logic                next_ed_q, next_ed_d;
  logic                enter_ed_q, enter_ed_d;
  logic                lock_rst_n_q, lock_rst_n_d;
  logic                locked_out_q, locked_out_d;
  logic                unlocked_q, unlocked_d;
  logic                busy_q, busy_d;

  assign raw_btn[BTN_NEXT]  = bus.next_btn;
  assign raw_btn[BTN_ENTER] = bus.enter_btn;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_btn[g]),
      .rise  (rise[g])
    );
  end

  // Outcome FSM: LED qualification, state timer, manual relock.
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == TW'(TMAX)) ? timer_q : timer_q + 1'b1;
    qf_d    = '0;
    qc_d    = '0;
    unique case (state_q)
      ST_ACTIVE: begin
        timer_d = '0;
        if (bus.lock_led == LED_LOCKOUT)
          qf_d = (qf_q == QW'(LED_QUAL_CYCLES - 1)) ? qf_q : qf_q + 1'b1;
        if (bus.lock_led == LED_UNLOCK)
          qc_d = (qc_q == QW'(LED_QUAL_CYCLES - 1)) ? qc_q : qc_q + 1'b1;
        // Current cycle plus the preceding LED_QUAL_CYCLES-1 must all match.
        if (bus.lock_led == LED_LOCKOUT && qf_q == QW'(LED_QUAL_CYCLES - 1))
          state_d = ST_LOCKOUT;
        else if (bus.lock_led == LED_UNLOCK && qc_q == QW'(LED_QUAL_CYCLES - 1))
          state_d = ST_UNLOCKED;
      end
      ST_LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) state_d = ST_RELOCK;
      end
      ST_UNLOCKED: begin
        // An enter press here is a manual relock; it never reaches the lock.
        if (rise[BTN_ENTER] || timer_q == TW'(UNLOCK_CYCLES - 1))
          state_d = ST_RELOCK;
      end
      ST_RELOCK: begin
        if (timer_q == TW'(RST_PULSE_CYCLES - 1)) state_d = ST_ACTIVE;
      end
      default: state_d = ST_RELOCK;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // Pulse pacing: one-deep pending flags, enter priority, gap counter.
  always_comb begin
    iss    = '0;
    pend_d = '0;
    gap_d  = GW'(GAP_CYCLES - 1);
    if (state_q == ST_ACTIVE) begin
      if (gap_q == '0) begin
        if (pend_q[BTN_ENTER])     iss[BTN_ENTER] = 1'b1;
        else if (pend_q[BTN_NEXT]) iss[BTN_NEXT]  = 1'b1;
      end
      for (int i = 0; i < NUM_BTNS; i++)
        pend_d[i] = pend_q[i] ? ~iss[i] : rise[i];
      if (iss == '0) gap_d = (gap_q == '0) ? gap_q : gap_q - 1'b1;
    end
    // Outside ACTIVE the gap is held loaded so the first pulse after
    // re-arm waits a full gap; pending flags are discarded.
    next_ed_d    = iss[BTN_NEXT];
    enter_ed_d   = iss[BTN_ENTER];
    lock_rst_n_d = (state_d != ST_RELOCK);
    locked_out_d = (state_d == ST_LOCKOUT);
    unlocked_d   = (state_d == ST_UNLOCKED);
    busy_d       = (state_d != ST_ACTIVE) || (pend_d != '0);
  end

  // State, counters and registered outputs; reset lands in RELOCK so the
  // core always gets a full re-arm pulse after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RELOCK;
      timer_q      <= '0;
      qf_q         <= '0;
      qc_q         <= '0;
      gap_q        <= '0;
      pend_q       <= '0;
      next_ed_q    <= 1'b0;
      enter_ed_q   <= 1'b0;
      lock_rst_n_q <= 1'b0;
      locked_out_q <= 1'b0;
      unlocked_q   <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      qf_q         <= qf_d;
      qc_q         <= qc_d;
      gap_q        <= gap_d;
      pend_q       <= pend_d;
      next_ed_q    <= next_ed_d;
      enter_ed_q   <= enter_ed_d;
      lock_rst_n_q <= lock_rst_n_d;
      locked_out_q <= locked_out_d;
      unlocked_q   <= unlocked_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.next_ed    = next_ed_q;
  assign bus.enter_ed   = enter_ed_q;
  assign bus.lock_rst_n = lock_rst_n_q;
  assign bus.locked_out = locked_out_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed scenarios followed by randomized
// button/LED traffic checked against a timing model.
module tb_lock_sequencer;

  localparam int D  = 4;
  localparam int G  = 2;
  localparam int LO = 20;
  localparam int UN = 10;
  localparam int RP = 2;
  // Raw rise to visible pulse: 2 sync + D debounce + 1 registered output.
  localparam int LAT = 2 + D + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lock_sequencer_if bus();

  lock_sequencer #(
    .DEBOUNCE_CYCLES  (D),
    .GAP_CYCLES       (G),
    .LOCKOUT_CYCLES   (LO),
    .UNLOCK_CYCLES    (UN),
    .RST_PULSE_CYCLES (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int nq[$];
  int eq[$];
  int both_cnt, lo_cnt, un_cnt, lr_cnt, lr_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr();
    nq.delete();
    eq.delete();
    both_cnt = 0; lo_cnt = 0; un_cnt = 0; lr_cnt = 0; lr_first = -1;
  endtask

  // One clock; sample everything on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (bus.next_ed === 1'b1)  nq.push_back(cyc);
    if (bus.enter_ed === 1'b1) eq.push_back(cyc);
    if (bus.next_ed === 1'b1 && bus.enter_ed === 1'b1) both_cnt++;
    if (bus.locked_out === 1'b1) lo_cnt++;
    if (bus.unlocked === 1'b1)   un_cnt++;
    if (bus.lock_rst_n === 1'b0) begin
      lr_cnt++;
      if (lr_first < 0) lr_first = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  int t0, tn, te, mode, a, b, hn, he;
  logic [3:0] prev, v;

  initial begin
    rst_n = 1'b0;
    bus.next_btn = 1'b0; bus.enter_btn = 1'b0; bus.lock_led = 4'h0;
    run(3);
    chk("rst_next_ed",    32'(bus.next_ed),    0);
    chk("rst_enter_ed",   32'(bus.enter_ed),   0);
    chk("rst_lock_rst_n", 32'(bus.lock_rst_n), 0);
    chk("rst_locked_out", 32'(bus.locked_out), 0);
    chk("rst_unlocked",   32'(bus.unlocked),   0);
    chk("rst_busy",       32'(bus.busy),       1);

    // Reset release: re-arm pulse then ACTIVE and idle.
    clr();
    rst_n = 1'b1;
    run(1);
    chk("rearm_low",  32'(bus.lock_rst_n), 0);
    chk("rearm_busy", 32'(bus.busy),       1);
    run(1);
    chk("rearm_high", 32'(bus.lock_rst_n), 1);
    chk("idle_busy",  32'(bus.busy),       0);
    run(10);
    // The release cycle itself falls before the first sample.
    chk("rearm_low_samples", lr_cnt, 1);
    chk("idle_pulses", nq.size() + eq.size(), 0);

    // Bouncing next press.
    clr();
    bus.next_btn = 1'b1; run(1);
    bus.next_btn = 1'b0; run(1);
    bus.next_btn = 1'b1; run(1);
    bus.next_btn = 1'b0; run(1);
    bus.next_btn = 1'b1; t0 = cyc;
    run(10);
    bus.next_btn = 1'b0;
    run(10);
    chk("bounce_count", nq.size(), 1);
    chk("bounce_time",  first_of(nq), t0 + LAT);
    chk("bounce_enter", eq.size(), 0);

    // Simultaneous presses: enter first, next one gap later.
    clr();
    bus.next_btn = 1'b1; bus.enter_btn = 1'b1; t0 = cyc;
    run(12);
    bus.next_btn = 1'b0; bus.enter_btn = 1'b0;
    run(10);
    chk("both_enter_count", eq.size(), 1);
    chk("both_enter_time",  first_of(eq), t0 + LAT);
    chk("both_next_count",  nq.size(), 1);
    chk("both_next_time",   first_of(nq), t0 + LAT + G);
    chk("both_overlap",     both_cnt, 0);

    // Single-cycle lockout pattern is a transient.
    clr();
    bus.lock_led = 4'hF; run(1);
    bus.lock_led = 4'h0; run(6);
    chk("glitch_lockout", lo_cnt, 0);

    // Held lockout pattern; a next press during lockout is discarded.
    clr();
    bus.lock_led = 4'hF; t0 = cyc;
    run(1);
    chk("lockout_qual1", 32'(bus.locked_out), 0);
    run(1);
    chk("lockout_qual2", 32'(bus.locked_out), 1);
    bus.next_btn = 1'b1;
    run(3);
    bus.lock_led = 4'h0;
    run(6);
    bus.next_btn = 1'b0;
    run(23);
    chk("lockout_len",     lo_cnt, LO);
    chk("lockout_rst_len", lr_cnt, RP);
    chk("lockout_rst_at",  lr_first, t0 + 2 + LO);
    chk("lockout_pulses",  nq.size() + eq.size(), 0);
    chk("lockout_busy",    32'(bus.busy), 0);

    // Unlock with manual relock by enter.
    clr();
    bus.lock_led = 4'hC; t0 = cyc;
    run(1);
    bus.enter_btn = 1'b1;
    run(2);
    bus.lock_led = 4'h0;
    run(9);
    bus.enter_btn = 1'b0;
    run(12);
    chk("manual_unl_len", un_cnt, 5);
    chk("manual_rst_at",  lr_first, t0 + 1 + 2 + D);
    chk("manual_rst_len", lr_cnt, RP);
    chk("manual_no_enter", eq.size() + nq.size(), 0);

    // Unlock with automatic relock.
    clr();
    bus.lock_led = 4'hC; t0 = cyc;
    run(3);
    bus.lock_led = 4'h0;
    run(17);
    chk("auto_unl_len", un_cnt, UN);
    chk("auto_rst_at",  lr_first, t0 + 2 + UN);
    chk("auto_rst_len", lr_cnt, RP);

    // Reset while enter_ed is out and next is still pending.
    clr();
    bus.next_btn = 1'b1; bus.enter_btn = 1'b1; t0 = cyc;
    run(LAT);
    chk("inflight_enter", 32'(bus.enter_ed), 1);
    chk("inflight_busy",  32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_enter",    32'(bus.enter_ed), 0);
    chk("abort_lock_rst", 32'(bus.lock_rst_n), 0);
    bus.next_btn = 1'b0; bus.enter_btn = 1'b0;
    run(2);
    clr();
    rst_n = 1'b1;
    run(20);
    chk("abort_no_stale",   nq.size() + eq.size(), 0);
    chk("abort_rearm_low",  lr_cnt, 1);
    chk("abort_rearm_high", 32'(bus.lock_rst_n), 1);

    // Randomized presses with LED noise that never qualifies.
    for (int it = 0; it < 8; it++) begin
      mode = $urandom_range(1, 3);
      a    = $urandom_range(0, 3);
      b    = $urandom_range(0, 3);
      hn   = $urandom_range(D + 2, D + 6);
      he   = $urandom_range(D + 2, D + 6);
      clr();
      t0   = cyc;
      prev = bus.lock_led;
      for (int k = 0; k < 40; k++) begin
        bus.next_btn  = mode[0] && k >= a && k < a + hn;
        bus.enter_btn = mode[1] && k >= b && k < b + he;
        v = 4'($urandom);
        if ((v == 4'hF && prev == 4'hF) || (v == 4'hC && prev == 4'hC)) v = 4'h3;
        bus.lock_led = v;
        prev = v;
        tick();
      end
      // Earliest issue is LAT after the raw rise; the later of two
      // requests (ties go to enter) waits at least G after the first.
      tn = t0 + a + LAT;
      te = t0 + b + LAT;
      if (mode == 3) begin
        if (b <= a) tn = (tn > te + G) ? tn : te + G;
        else        te = (te > tn + G) ? te : tn + G;
      end
      chk("rnd_next_count",  nq.size(), mode[0] ? 1 : 0);
      chk("rnd_enter_count", eq.size(), mode[1] ? 1 : 0);
      if (mode[0]) chk("rnd_next_time",  first_of(nq), tn);
      if (mode[1]) chk("rnd_enter_time", first_of(eq), te);
      chk("rnd_overlap",  both_cnt, 0);
      chk("rnd_outcomes", lo_cnt + un_cnt + lr_cnt, 0);
    end
    bus.lock_led = 4'h0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
